// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Buffered N-channel framebuffer write arbiter. Each producer
//               feeds its own small FIFO; a round-robin arbiter pops one
//               pixel per cycle into a registered output stage that clips
//               off-screen pixels, drops colour-keyed pixels and forms the
//               linear framebuffer address.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       X_W        = 10,
  parameter int unsigned       Y_W        = 10,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       FB_WIDTH   = 320,
  parameter int unsigned       FB_HEIGHT  = 240,
  parameter int unsigned       ADDR_W     = 17,
  parameter logic [DATA_W-1:0] KEY_COLOR  = '0
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*X_W-1:0]    ch_x,
  input  logic [NUM_CH*Y_W-1:0]    ch_y,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_key_en,
  output logic                     wr_en,
  output logic [X_W-1:0]           wr_x,
  output logic [Y_W-1:0]           wr_y,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [15:0]              clip_count,
  output logic                     idle
);

  localparam int unsigned c_CH_W  = $clog2(NUM_CH);
  localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;
  localparam int unsigned c_ENT_W = X_W + Y_W + DATA_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CH_W-1:0]  c_LAST = c_CH_W'(NUM_CH - 1);
  localparam logic [31:0]        c_FB_W = 32'(FB_WIDTH);
  localparam logic [31:0]        c_FB_H = 32'(FB_HEIGHT);

  // Per-channel FIFO state
  logic [c_ENT_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [c_ENT_W-1:0] mem_d [NUM_CH][FIFO_DEPTH];
  logic [c_PTR_W-1:0] wptr_q [NUM_CH];
  logic [c_PTR_W-1:0] wptr_d [NUM_CH];
  logic [c_PTR_W-1:0] rptr_q [NUM_CH];
  logic [c_PTR_W-1:0] rptr_d [NUM_CH];
  logic [c_CNT_W-1:0] cnt_q  [NUM_CH];
  logic [c_CNT_W-1:0] cnt_d  [NUM_CH];

  // Arbiter and pipeline state
  logic [c_CH_W-1:0]  rr_q, rr_d;
  logic               pend_q, pend_d;
  logic [c_ENT_W-1:0] pend_ent_q, pend_ent_d;
  logic               wr_en_q, wr_en_d;
  logic [X_W-1:0]     wr_x_q, wr_x_d;
  logic [Y_W-1:0]     wr_y_q, wr_y_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [15:0]        clip_q, clip_d;

  logic [c_ENT_W-1:0] w_entry [NUM_CH];
  logic [NUM_CH-1:0]  w_push;
  logic [NUM_CH-1:0]  w_pop;
  logic               w_grant_vld;
  logic [c_CH_W-1:0]  w_grant;
  logic [31:0]        w_idx;
  logic [c_ENT_W-1:0] w_pop_ent;
  logic               w_any;
  logic [X_W-1:0]     w_px;
  logic [Y_W-1:0]     w_py;
  logic [DATA_W-1:0]  w_pd;
  logic               w_pk;
  logic               w_clip;

  // Unpack producer buses; ready depends only on registered occupancy
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_entry[i] = {ch_x[i*X_W +: X_W], ch_y[i*Y_W +: Y_W],
                         ch_data[i*DATA_W +: DATA_W], ch_key_en[i]};
    assign ch_ready[i] = (cnt_q[i] != c_FULL);
    assign w_push[i]   = ch_valid[i] & ch_ready[i];
    assign w_pop[i]    = w_grant_vld && (w_grant == c_CH_W'(i));
  end

  // Round-robin search for the first non-empty FIFO starting at rr_q
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    rr_d        = rr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = 32'(rr_q) + 32'(k);
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_grant_vld && (cnt_q[c_CH_W'(w_idx)] != '0)) begin
        w_grant_vld = 1'b1;
        w_grant     = c_CH_W'(w_idx);
      end
    end
    if (w_grant_vld) rr_d = (w_grant == c_LAST) ? '0 : w_grant + c_CH_W'(1);
  end

  assign w_pop_ent = mem_q[w_grant][rptr_q[w_grant]];

  // FIFO next state: write on push, advance read on pop, track occupancy
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) begin
        mem_d[i][wptr_q[i]] = w_entry[i];
        wptr_d[i]           = wptr_q[i] + c_PTR_W'(1);
      end
      if (w_pop[i]) rptr_d[i] = rptr_q[i] + c_PTR_W'(1);
      case ({w_push[i], w_pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + c_CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - c_CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Popped entry moves into the pending stage; payload held when idle
  always_comb begin
    pend_d     = w_grant_vld;
    pend_ent_d = w_grant_vld ? w_pop_ent : pend_ent_q;
  end

  assign {w_px, w_py, w_pd, w_pk} = pend_ent_q;
  assign w_clip = (32'(w_px) >= c_FB_W) || (32'(w_py) >= c_FB_H);

  // Output stage: clip, colour-key drop, or framebuffer write
  always_comb begin
    wr_en_d   = 1'b0;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    clip_d    = clip_q;
    if (pend_q) begin
      if (w_clip) begin
        if (clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
      end else if (!(w_pk && (w_pd == KEY_COLOR))) begin
        wr_en_d   = 1'b1;
        wr_x_d    = w_px;
        wr_y_d    = w_py;
        wr_data_d = w_pd;
        wr_addr_d = ADDR_W'(32'(w_py) * c_FB_W + 32'(w_px));
      end
    end
  end

  // FIFO storage needs no reset: occupancy governs what is readable
  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q       <= '0;
      pend_q     <= 1'b0;
      pend_ent_q <= '0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clip_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      pend_q     <= pend_d;
      pend_ent_q <= pend_ent_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clip_q     <= clip_d;
    end
  end

  // Idle when nothing is queued and nothing is waiting in the output stage
  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_q[i] != '0) w_any = 1'b1;
    end
  end

  assign idle       = !w_any && !pend_q;
  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign clip_count = clip_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Randomised self-checking bench for fb_write_arbiter with a
//               queue-based reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

  localparam int N = 4, XW = 10, YW = 10, DW = 8, DEPTH = 4, AW = 17;
  localparam int FBW = 320, FBH = 240;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
    logic          k;
  } pix_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    ch_valid = '0;
  logic [N-1:0]    ch_ready;
  logic [N*XW-1:0] ch_x = '0;
  logic [N*YW-1:0] ch_y = '0;
  logic [N*DW-1:0] ch_data = '0;
  logic [N-1:0]    ch_key_en = '0;
  logic            wr_en;
  logic [XW-1:0]   wr_x;
  logic [YW-1:0]   wr_y;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [15:0]     clip_count;
  logic            idle;

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_x      (ch_x),
    .ch_y      (ch_y),
    .ch_data   (ch_data),
    .ch_key_en (ch_key_en),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clip_count(clip_count),
    .idle      (idle)
  );

  // Reference model state
  pix_t          mq [N][$];
  pix_t          src[N][$];
  logic [N-1:0]  hold;
  int            rate;
  int            rr;
  logic          st1_v;
  pix_t          st1;
  logic          exp_wr_en;
  logic [XW-1:0] exp_x;
  logic [YW-1:0] exp_y;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [15:0]   exp_clip;

  int n_pass = 0, n_total = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      src[i].delete();
    end
    hold = '0; ch_valid = '0; rr = 0; st1_v = 1'b0; st1 = '0;
    exp_wr_en = 1'b0; exp_x = '0; exp_y = '0; exp_addr = '0; exp_data = '0; exp_clip = '0;
  endtask

  function automatic pix_t cur_pix(input int i);
    pix_t p;
    p.x = ch_x[i*XW +: XW];
    p.y = ch_y[i*YW +: YW];
    p.d = ch_data[i*DW +: DW];
    p.k = ch_key_en[i];
    return p;
  endfunction

  // One clock edge of the specified behaviour, using the inputs present at it
  task automatic model_edge(output logic [N-1:0] acc);
    int g;
    for (int i = 0; i < N; i++) acc[i] = ch_valid[i] && (mq[i].size() < DEPTH);
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
    end
    exp_wr_en = 1'b0;
    if (st1_v) begin
      if (int'(st1.x) >= FBW || int'(st1.y) >= FBH) begin
        if (exp_clip != 16'hFFFF) exp_clip = exp_clip + 16'd1;
      end else if (!(st1.k && st1.d == 8'h00)) begin
        exp_wr_en = 1'b1;
        exp_x     = st1.x;
        exp_y     = st1.y;
        exp_data  = st1.d;
        exp_addr  = AW'(int'(st1.y) * FBW + int'(st1.x));
      end
    end
    st1_v = (g >= 0);
    if (g >= 0) begin
      st1 = mq[g].pop_front();
      rr  = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(cur_pix(i));
  endtask

  // Producers: present the head of each source queue, holding while unaccepted
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!hold[i]) begin
        if (src[i].size() > 0 && $urandom_range(99) < rate) begin
          ch_valid[i]              = 1'b1;
          ch_x[i*XW +: XW]         = src[i][0].x;
          ch_y[i*YW +: YW]         = src[i][0].y;
          ch_data[i*DW +: DW]      = src[i][0].d;
          ch_key_en[i]             = src[i][0].k;
        end else begin
          ch_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    pix_t         tmp;
    @(posedge clk);
    #1;
    acc = '0;
    if (!reset) model_edge(acc);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) tmp = src[i].pop_front();
      hold[i] = ch_valid[i] && !acc[i];
    end
    drive();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst ch_ready", 32'(ch_ready), 32'hF);
    chk("rst wr_en", 32'(wr_en), 32'h0);
    chk("rst clip_count", 32'(clip_count), 32'h0);
    chk("rst idle", 32'(idle), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
  endtask

  task automatic add(input int c, input int x, input int y, input int d, input int k);
    pix_t p;
    p.x = XW'(x); p.y = YW'(y); p.d = DW'(d); p.k = (k != 0);
    src[c].push_back(p);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin : p_cmp
    logic [N-1:0] er;
    logic         ei;
    if (chk_on) begin
      ei = !st1_v;
      for (int i = 0; i < N; i++) begin
        er[i] = (mq[i].size() < DEPTH);
        if (mq[i].size() != 0) ei = 1'b0;
      end
      chk("ch_ready", 32'(ch_ready), 32'(er));
      chk("idle", 32'(idle), 32'(ei));
      chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
      chk("wr_x", 32'(wr_x), 32'(exp_x));
      chk("wr_y", 32'(wr_y), 32'(exp_y));
      chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
      chk("wr_data", 32'(wr_data), 32'(exp_data));
      chk("clip_count", 32'(clip_count), 32'(exp_clip));
    end
  end

  initial begin
    rate = 100;
    model_reset();
    do_reset();
    chk_on = 1'b1;

    // Single pixel: two-cycle latency and address formation
    add(0, 5, 2, 8'hAA, 0);
    drive();
    step();
    step();
    chk("t1 idle busy", 32'(idle), 32'h0);
    step();
    chk("t1 wr_en", 32'(wr_en), 32'h1);
    chk("t1 wr_x", 32'(wr_x), 32'd5);
    chk("t1 wr_y", 32'(wr_y), 32'd2);
    chk("t1 wr_addr", 32'(wr_addr), 32'd645);
    chk("t1 wr_data", 32'(wr_data), 32'hAA);
    chk("t1 idle", 32'(idle), 32'h1);

    // Round-robin across four busy channels
    do_reset();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 3; j++) add(c, c, j, 16 * c + j + 1, 0);
    drive();
    step();
    step();
    for (int n = 0; n < 12; n++) begin
      step();
      chk("t2 wr_en", 32'(wr_en), 32'h1);
      chk("t2 wr_data", 32'(wr_data), 32'(16 * (n % 4) + n / 4 + 1));
    end

    // Backpressure, then reset with entries queued
    do_reset();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 8; j++) add(c, j, c, 16 * c + j + 1, 0);
    drive();
    repeat (4) step();
    chk("t3 ready2 e3", 32'(ch_ready[2]), 32'h1);
    step();
    chk("t3 ready2 full", 32'(ch_ready[2]), 32'h0);
    chk("t3 ready1 full", 32'(ch_ready[1]), 32'h0);
    repeat (3) step();
    do_reset();
    repeat (3) step();
    chk("t6 no write", 32'(wr_en), 32'h0);

    // Clipping boundaries
    do_reset();
    add(0, 320, 0, 8'h11, 0);
    add(0, 0, 240, 8'h22, 0);
    add(0, 319, 239, 8'h33, 0);
    drive();
    repeat (3) step();
    chk("t4 clip1", 32'(clip_count), 32'd1);
    step();
    chk("t4 clip2", 32'(clip_count), 32'd2);
    chk("t4 clip wr_en", 32'(wr_en), 32'h0);
    step();
    chk("t4 last wr_en", 32'(wr_en), 32'h1);
    chk("t4 last addr", 32'(wr_addr), 32'd76799);
    chk("t4 clip hold", 32'(clip_count), 32'd2);

    // Colour key
    do_reset();
    add(0, 10, 10, 8'h00, 1);
    add(0, 11, 10, 8'h00, 0);
    drive();
    repeat (3) step();
    chk("t5 keyed wr_en", 32'(wr_en), 32'h0);
    chk("t5 keyed clip", 32'(clip_count), 32'h0);
    step();
    chk("t5 unkeyed wr_en", 32'(wr_en), 32'h1);
    chk("t5 unkeyed x", 32'(wr_x), 32'd11);
    chk("t5 unkeyed addr", 32'(wr_addr), 32'd3211);

    // Randomised traffic
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      rate = $urandom_range(30, 100);
      if (seg == 3) do_reset();
      repeat (250) begin
        for (int i = 0; i < N; i++) begin
          if (src[i].size() < 2)
            add(i, $urandom_range(0, 335), $urandom_range(0, 255),
                ($urandom_range(3) == 0) ? 0 : $urandom_range(255), $urandom_range(1));
        end
        step();
      end
    end
    repeat (40) step();
    chk("drain idle", 32'(idle), 32'h1);
    chk("drain ready", 32'(ch_ready), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
